// File: rtl/fsm_urt_rx.sv
// UART receiver control FSM: detects the start edge and sequences the shared
// counter, sampler, deserializer and start/parity/stop checkers through one frame.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle, waiting for a start-bit falling edge
// START  | start bit in flight, start checker enabled
// DATA   | 8 data bits, deserializer strobed at each bit end
// PARITY | parity bit (only when parity was latched at frame start)
// STOP   | stop bit, stop checker enabled
// DONE   | one cycle: publish error flags, pulse data_valid if clean
module fsm_urt_rx #(
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK_fsm,
    input  logic                      RST_fsm,
    input  logic                      RX_IN_fsm,
    input  logic                      PAR_EN_fsm,
    input  logic [PRESCALE_WIDTH-1:0] Prescale_fsm,
    input  logic [3:0]                edge_cnt_fsm,
    input  logic [3:0]                bit_cnt_fsm,
    input  logic                      strt_glitch_fsm,
    input  logic                      par_err_fsm,
    input  logic                      stp_err_fsm,
    output logic                      enable_fsm,
    output logic                      dat_samp_en_fsm,
    output logic                      deser_en_fsm,
    output logic                      strt_chk_en_fsm,
    output logic                      par_chk_en_fsm,
    output logic                      stp_chk_en_fsm,
    output logic                      data_valid_fsm,
    output logic                      par_error_fsm,
    output logic                      stp_error_fsm
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t state;
    logic   par_en_q;
    logic   par_pend;
    logic   stp_pend;
    logic   bit_end;
    logic   p_legal;

    assign bit_end = (PRESCALE_WIDTH'(edge_cnt_fsm) == (Prescale_fsm - PRESCALE_WIDTH'(1)));
    assign p_legal = (Prescale_fsm == PRESCALE_WIDTH'(8)) || (Prescale_fsm == PRESCALE_WIDTH'(16));

    always_ff @(posedge CLK_fsm) begin
        if (!RST_fsm) begin
            state         <= IDLE;
            par_en_q      <= 1'b0;
            par_pend      <= 1'b0;
            stp_pend      <= 1'b0;
            par_error_fsm <= 1'b0;
            stp_error_fsm <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!RX_IN_fsm && p_legal) begin
                        state    <= START;
                        par_en_q <= PAR_EN_fsm;
                        par_pend <= 1'b0;
                        stp_pend <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) state <= strt_glitch_fsm ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_end && bit_cnt_fsm == 4'd8) state <= par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (bit_end) begin
                        par_pend <= par_err_fsm;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        stp_pend <= stp_err_fsm;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    par_error_fsm <= par_pend;
                    stp_error_fsm <= stp_pend;
                    // Line already low here means a back-to-back frame: skip IDLE.
                    if (!RX_IN_fsm) begin
                        state    <= START;
                        par_en_q <= PAR_EN_fsm;
                        par_pend <= 1'b0;
                        stp_pend <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        enable_fsm      = 1'b0;
        dat_samp_en_fsm = 1'b0;
        deser_en_fsm    = 1'b0;
        strt_chk_en_fsm = 1'b0;
        par_chk_en_fsm  = 1'b0;
        stp_chk_en_fsm  = 1'b0;
        data_valid_fsm  = 1'b0;
        case (state)
            START: begin
                enable_fsm      = 1'b1;
                dat_samp_en_fsm = 1'b1;
                strt_chk_en_fsm = 1'b1;
            end
            DATA: begin
                enable_fsm      = 1'b1;
                dat_samp_en_fsm = 1'b1;
                deser_en_fsm    = bit_end;
            end
            PARITY: begin
                enable_fsm      = 1'b1;
                dat_samp_en_fsm = 1'b1;
                par_chk_en_fsm  = 1'b1;
            end
            STOP: begin
                enable_fsm      = 1'b1;
                dat_samp_en_fsm = 1'b1;
                stp_chk_en_fsm  = 1'b1;
            end
            DONE: begin
                data_valid_fsm = !par_pend && !stp_pend;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fsm_urt_rx.sv
// Scoreboard bench for fsm_urt_rx: frame-level timing model feeds an expected-event
// queue; a negedge monitor pops it whenever the DUT strobes, ends a frame, or pulses valid.
module tb_fsm_urt_rx;

    logic       clk = 1'b0;
    logic       rst_n, rx, par_en, glitch, perr, serr;
    logic [4:0] presc;
    logic [3:0] edge_cnt, bit_cnt;
    logic       enable, samp_en, deser_en, strt_en, par_en_chk, stp_en;
    logic       data_valid, par_error, stp_error;

    always #5 clk = ~clk;

    fsm_urt_rx #(.PRESCALE_WIDTH(5)) dut (
        .CLK_fsm        (clk),
        .RST_fsm        (rst_n),
        .RX_IN_fsm      (rx),
        .PAR_EN_fsm     (par_en),
        .Prescale_fsm   (presc),
        .edge_cnt_fsm   (edge_cnt),
        .bit_cnt_fsm    (bit_cnt),
        .strt_glitch_fsm(glitch),
        .par_err_fsm    (perr),
        .stp_err_fsm    (serr),
        .enable_fsm     (enable),
        .dat_samp_en_fsm(samp_en),
        .deser_en_fsm   (deser_en),
        .strt_chk_en_fsm(strt_en),
        .par_chk_en_fsm (par_en_chk),
        .stp_chk_en_fsm (stp_en),
        .data_valid_fsm (data_valid),
        .par_error_fsm  (par_error),
        .stp_error_fsm  (stp_error)
    );

    // Shared edge/bit counter the FSM drives through enable.
    always @(posedge clk) begin
        if (!enable) begin
            edge_cnt <= 4'd0;
            bit_cnt  <= 4'd0;
        end else if ({1'b0, edge_cnt} == presc - 5'd1) begin
            edge_cnt <= 4'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 4'd1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_end;
        int cyc;
        bit dv;
        bit pe;
        bit se;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  m_pe  = 1'b0;
    bit  m_se  = 1'b0;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_ev(input bit is_end, input int c, input bit dv, input bit pe, input bit se);
        ev_t e;
        e.is_end = is_end;
        e.cyc    = c;
        e.dv     = dv;
        e.pe     = pe;
        e.se     = se;
        exp_q.push_back(e);
    endtask

    bit  armed    = 1'b0;
    bit  prev_en  = 1'b0;
    bit  flag_due = 1'b0;
    ev_t fe, mev;

    always @(negedge clk) begin
        if (armed) begin
            if (flag_due) begin
                check("par_error_flag", par_error, fe.pe);
                check("stp_error_flag", stp_error, fe.se);
                flag_due = 1'b0;
            end
            if (deser_en) begin
                if (exp_q.size() == 0 || exp_q[0].is_end) begin
                    n_cmp++; n_err++;
                    $display("FAIL stray_deser: got pulse at cycle %0d expected none", cyc);
                end else begin
                    mev = exp_q.pop_front();
                    check("deser_cycle", cyc, mev.cyc);
                end
            end
            if (prev_en && !enable) begin
                if (exp_q.size() == 0 || !exp_q[0].is_end) begin
                    n_cmp++; n_err++;
                    $display("FAIL stray_frame_end: got end at cycle %0d expected %0s", cyc,
                             exp_q.size() == 0 ? "none" : "deser pulse");
                end else begin
                    mev = exp_q.pop_front();
                    check("frame_end_cycle", cyc, mev.cyc);
                    check("data_valid", data_valid, mev.dv);
                    fe       = mev;
                    flag_due = 1'b1;
                end
            end else if (data_valid) begin
                n_cmp++; n_err++;
                $display("FAIL stray_valid: got valid at cycle %0d expected none", cyc);
            end
            prev_en = enable;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame starting at the current cycle (t0) and queues what the
    // frame must produce. abort_k>0 pulses reset at cycle t0+abort_k.
    task automatic send_frame(input int p, input bit pen, input bit gl, input bit pe, input bit se,
                              input int abort_k, input bit b2b);
        int t0, t_end, nbits;
        bit npe;
        t0     = cyc;
        presc  = 5'(p);
        par_en = pen;
        glitch = gl;
        perr   = pe;
        serr   = se;
        rx     = 1'b0;
        nbits  = pen ? 11 : 10;
        if (abort_k > 0)  t_end = t0 + abort_k + 1;
        else if (gl)      t_end = t0 + p + 1;
        else              t_end = t0 + nbits * p + 1;
        if (!gl) begin
            for (int k = 2; k <= 9; k++)
                if (abort_k == 0 || k * p <= abort_k) push_ev(1'b0, t0 + k * p, 1'b0, 1'b0, 1'b0);
        end
        if (abort_k > 0) begin
            m_pe = 1'b0;
            m_se = 1'b0;
            push_ev(1'b1, t_end, 1'b0, m_pe, m_se);
        end else if (gl) begin
            push_ev(1'b1, t_end, 1'b0, m_pe, m_se);
        end else begin
            npe  = pen & pe;
            m_pe = npe;
            m_se = se;
            push_ev(1'b1, t_end, !npe && !se, m_pe, m_se);
        end
        while (cyc < t_end) begin
            step();
            rx     = 1'b1;
            par_en = 1'($urandom_range(0, 1));
            rst_n  = !(abort_k > 0 && cyc == t0 + abort_k);
        end
        rst_n = 1'b1;
        if (!b2b || abort_k > 0) repeat ($urandom_range(1, 4)) step();
    endtask

    initial begin
        rst_n  = 1'b0;
        rx     = 1'b1;
        par_en = 1'b0;
        glitch = 1'b0;
        perr   = 1'b0;
        serr   = 1'b0;
        presc  = 5'd8;
        repeat (3) step();
        @(negedge clk);
        check("rst_enable", enable, 0);
        check("rst_samp_en", samp_en, 0);
        check("rst_deser_en", deser_en, 0);
        check("rst_strt_en", strt_en, 0);
        check("rst_par_chk_en", par_en_chk, 0);
        check("rst_stp_chk_en", stp_en, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_par_error", par_error, 0);
        check("rst_stp_error", stp_error, 0);
        armed = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (2) step();

        send_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // clean P=8 frame
        send_frame(16, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);  // parity error P=16
        send_frame(8, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);   // start glitch, flags hold
        send_frame(8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);   // stop error, back-to-back
        send_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        send_frame(8, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);   // parity off ignores par_err
        send_frame(8, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 4 * 8 + 3, 1'b0);  // reset in data bit 4
        send_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        presc = 5'd12;
        rx    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 5 == 0) check("illegal_prescale_enable", enable, 0);
            step();
        end
        rx = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 30; i++) begin
            send_frame($urandom_range(0, 1) ? 16 : 8, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0), 0, 1'($urandom_range(0, 1)));
        end
        rx = 1'b1;
        repeat (5) step();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
